jk_bank_arbiter: RTL and testbench
==================================

# jk_bank_arbiter

Shares one WIDTH-bit bank of master-slave JK flip-flops between N_REQ requesters. Each requester submits per-bit J/K commands; the block arbitrates round-robin, then sequences the winning command through explicit master-capture and slave-transfer phases. The bank state is exposed as `q`/`q_bar`. It is the controller layer above the single-bit JK element, for designs where several agents set, reset or toggle shared flag bits.

## Interface
- `N_REQ`, 4, number of requesters (2..16)
- `WIDTH`, 8, number of JK bits in the bank
- `clk`  in  1  single clock; all state changes on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `req`  in  N_REQ  request per requester; held high until its `done` bit is seen
- `req_j`  in  N_REQ*WIDTH  J vector, requester i at bits [i*WIDTH +: WIDTH]; stable while `req[i]` high
- `req_k`  in  N_REQ*WIDTH  K vector, same packing
- `done`  out  N_REQ  one-hot, one-cycle completion pulse to the owner
- `busy`  out  1  high whenever state != IDLE
- `owner`  out  $clog2(N_REQ)  index of the current grantee; valid while `busy`
- `q`  out  WIDTH  slave (visible) bank state
- `q_bar`  out  WIDTH  always ~q

## Operation
- Per-bit JK rule: J=0,K=0 hold; J=0,K=1 clear; J=1,K=0 set; J=1,K=1 toggle.
- FSM states:
  - IDLE: if any `req` is high, select the winner round-robin starting at `rr_ptr`; latch `owner`, `j_lat`, `k_lat`; go to MASTER. Otherwise stay in IDLE.
  - MASTER: `master <= jk_next(q, j_lat, k_lat)`; `q` is unchanged; go to SLAVE.
  - SLAVE: `q <= master`; go to DONE.
  - DONE: `done[owner]=1` (combinational from state); `rr_ptr <= owner+1` (mod N_REQ); no arbitration this cycle; go to IDLE.
- Round-robin: the lowest index at or after `rr_ptr` wins, wrapping modulo N_REQ. `rr_ptr` resets to 0.
- J/K are sampled only in IDLE. If `req[owner]` drops mid-operation, or J/K change, the latched command still completes, and `done` still pulses.
- Requesters must drop `req` (or present a new command) at the edge that ends DONE. A `req` still high in the following IDLE is treated as a new request.
- An all-hold command (J=K=0) runs the full sequence and pulses `done`.
- Requests arriving while `busy` wait; there is no queueing beyond the level-held `req`.
- Reset values: state=IDLE, `q`=0, `q_bar`=all ones, `master`=0, `done`=0, `busy`=0, `owner`=0, `rr_ptr`=0.
- Reset mid-operation discards the in-flight command: no `done` pulse, and `q` goes to 0 even if SLAVE had been reached. The requester must re-request.

## Timing
- Edge E0 (IDLE with `req` high): grant latched, `busy`=1 from E0.
- Edge E1: `master` updated.
- Edge E2: `q`/`q_bar` show the new value.
- Cycle after E2: `done` pulse.
- Edge E3: back in IDLE.
- Throughput is one command per 4 cycles under continuous contention.
- `q` never changes in the same edge as `master`: this is the master/slave separation.
- No combinational path from `req*` to any output.

## Structure
- Package `jk_ctrl_pkg`:
  - state enum (IDLE, MASTER, SLAVE, DONE)
  - JK encodings JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10, JK_TGL=2'b11
  - function `jk_next(q, j, k)` (bitwise, WIDTH-agnostic via parameterized use)
- Sub-module `jk_ms_bank`: the WIDTH-bit master and slave registers.
  - Inputs: `master_en`, `slave_en`, `j`, `k`.
  - Outputs: `q`, `q_bar`.
  - Synchronous active-low reset.
- The top level holds the FSM, arbiter and latches.

## Test plan
Defaults: N_REQ=4, WIDTH=8.
1. Reset: `rst_n`=0 for 2 cycles with `req`=4'hF -> `q`=8'h00, `q_bar`=8'hFF, `busy`=0, `done`=0; no grant taken while in reset.
2. Single set: from `q`=00, `req[0]` with J=8'hF0, K=8'h00 -> `q`=00 through E1, `q`=F0 after E2, `done`=4'b0001 for exactly 1 cycle, `busy` low after E3.
3. Mixed rule: `q`=8'hAA, `req[2]` with J=8'h0F, K=8'h3C -> `q`=8'h87, `q_bar`=8'h78, `done`=4'b0100.
4. Contention: `req`=4'hF held and each dropped on its `done` -> grant order 0,1,2,3, one `done` every 4 cycles. Then `req[0]` and `req[2]` together with `rr_ptr`=0 -> 0 then 2. After owner 3 completes, `req[3]` and `req[1]` together -> 1 served before 3.
5. Toggle plus req dropped early: `q`=F0, `req[1]` with J=K=8'hFF, `req[1]` dropped in MASTER -> `q`=0F and `done[1]` still pulses.
6. Reset mid-op: `rst_n`=0 for one cycle while in SLAVE with a pending set of 8'hFF -> `q`=00, no `done`, state IDLE, `rr_ptr`=0. A re-request then completes normally.

Source files
------------

// File: rtl/jk_ctrl_pkg.sv
// Shared types and the per-bit JK next-state rule for the JK bank controller.
package jk_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MASTER = 2'd1,
    SLAVE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Widest bank the helper supports; callers cast in and out at their width.
  localparam int unsigned JK_MAX_W = 64;

  // Bitwise JK rule: {j,k} = hold / clear / set / toggle.
  function automatic logic [JK_MAX_W-1:0] jk_next(
    input logic [JK_MAX_W-1:0] q,
    input logic [JK_MAX_W-1:0] j,
    input logic [JK_MAX_W-1:0] k
  );
    logic [JK_MAX_W-1:0] r;
    r = q;
    for (int b = 0; b < JK_MAX_W; b++) begin
      case ({j[b], k[b]})
        JK_HOLD: r[b] = q[b];
        JK_CLR:  r[b] = 1'b0;
        JK_SET:  r[b] = 1'b1;
        JK_TGL:  r[b] = ~q[b];
        default: r[b] = q[b];
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/jk_ms_bank.sv
// WIDTH-bit master-slave JK bank: master captures the JK result, slave publishes it.
module jk_ms_bank
  import jk_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             master_en,
  input  logic             slave_en,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  logic [WIDTH-1:0] master;

  // Master and slave stages; q_bar is kept as its own register so it is never a gate after q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      master <= '0;
      q      <= '0;
      q_bar  <= '1;
    end else begin
      if (master_en) begin
        master <= WIDTH'(jk_next(JK_MAX_W'(q), JK_MAX_W'(j), JK_MAX_W'(k)));
      end
      if (slave_en) begin
        q     <= master;
        q_bar <= ~master;
      end
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that sequences one requester's JK command at a time through a shared bank.
module jk_bank_arbiter
  import jk_ctrl_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_j,
  input  logic [N_REQ*WIDTH-1:0] req_k,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [PTR_W-1:0]       owner,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       q_bar
);

  state_t           state, state_nxt;
  logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0] owner_nxt;
  logic [WIDTH-1:0] j_lat, j_lat_nxt;
  logic [WIDTH-1:0] k_lat, k_lat_nxt;
  logic [N_REQ-1:0] done_nxt;
  logic             busy_nxt;
  logic             master_en, slave_en;

  logic [PTR_W-1:0] winner;
  logic             any_req;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  // Round-robin pick: scan offsets high to low so the nearest index at/after rr_ptr wins.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(N_REQ)) begin
        sum = sum - (PTR_W+1)'(N_REQ);
      end
      idx = PTR_W'(sum);
      if (req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic for the grant/master/slave/done sequence.
  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    owner_nxt  = owner;
    j_lat_nxt  = j_lat;
    k_lat_nxt  = k_lat;
    done_nxt   = '0;
    master_en  = 1'b0;
    slave_en   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          owner_nxt = winner;
          j_lat_nxt = req_j[winner*WIDTH +: WIDTH];
          k_lat_nxt = req_k[winner*WIDTH +: WIDTH];
          state_nxt = MASTER;
        end
      end
      MASTER: begin
        master_en = 1'b1;
        state_nxt = SLAVE;
      end
      SLAVE: begin
        slave_en  = 1'b1;
        done_nxt  = N_REQ'(1) << owner;
        state_nxt = DONE;
      end
      DONE: begin
        rr_ptr_nxt = (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + PTR_W'(1);
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State and control registers with synchronous reset; reset drops any in-flight command.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      j_lat  <= '0;
      k_lat  <= '0;
      done   <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      owner  <= owner_nxt;
      j_lat  <= j_lat_nxt;
      k_lat  <= k_lat_nxt;
      done   <= done_nxt;
      busy   <= busy_nxt;
    end
  end

  jk_ms_bank #(.WIDTH(WIDTH)) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .master_en (master_en),
    .slave_en  (slave_en),
    .j         (j_lat),
    .k         (k_lat),
    .q         (q),
    .q_bar     (q_bar)
  );

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter: directed commands with hand-computed bank results.
module tb_jk_bank_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned WIDTH = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_j;
  logic [N_REQ*WIDTH-1:0] req_k;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [1:0]             owner;
  logic [WIDTH-1:0]       q;
  logic [WIDTH-1:0]       q_bar;

  typedef struct packed {
    logic [N_REQ-1:0] done;
    logic [WIDTH-1:0] q;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  jk_bank_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .req_j (req_j),
    .req_k (req_k),
    .done  (done),
    .busy  (busy),
    .owner (owner),
    .q     (q),
    .q_bar (q_bar)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse pops one expected completion.
  always @(negedge clk) begin : mon
    exp_t       e;
    logic [7:0] qb;
    if (done !== '0) begin
      if (sb.size() == 0) begin
        check("unexpected done", 32'(done), 32'(0));
      end else begin
        e  = sb.pop_front();
        qb = ~e.q;
        check("sb done", 32'(done), 32'(e.done));
        check("sb q", 32'(q), 32'(e.q));
        check("sb q_bar", 32'(q_bar), 32'(qb));
      end
    end
  end

  task automatic set_cmd(input int i, input logic [7:0] j, input logic [7:0] k);
    req_j[i*WIDTH +: WIDTH] = j;
    req_k[i*WIDTH +: WIDTH] = k;
  endtask

  task automatic expect_done(input int i, input logic [7:0] qv);
    exp_t e;
    e.done    = '0;
    e.done[i] = 1'b1;
    e.q       = qv;
    sb.push_back(e);
  endtask

  // Wait (bounded) for the next done pulse; check who got it and after how many cycles.
  task automatic wait_grant(input int i, input int gap);
    int         cnt;
    bit         got;
    logic [3:0] oh;
    cnt   = 0;
    got   = 0;
    oh    = '0;
    oh[i] = 1'b1;
    while (!got && cnt < 12) begin
      @(negedge clk);
      cnt++;
      if (done !== '0) got = 1;
    end
    check("grant order", 32'(done), 32'(oh));
    check("grant latency", 32'(cnt), 32'(gap));
    req[i] = 1'b0;
  endtask

  task automatic do_cmd(input int i, input logic [7:0] j, input logic [7:0] k, input logic [7:0] qv);
    set_cmd(i, j, k);
    expect_done(i, qv);
    req[i] = 1'b1;
    wait_grant(i, 3);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every requester asserted
    rst_n = 1'b0;
    req   = '1;
    req_j = '1;
    req_k = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset q", 32'(q), 32'h00);
    check("reset q_bar", 32'(q_bar), 32'hFF);
    check("reset busy", 32'(busy), 32'(0));
    check("reset done", 32'(done), 32'(0));
    req   = '0;
    rst_n = 1'b1;
    @(negedge clk);
    check("no grant from reset", 32'(busy), 32'(0));

    // Single set, cycle by cycle
    set_cmd(0, 8'hF0, 8'h00);
    expect_done(0, 8'hF0);
    req[0] = 1'b1;
    @(posedge clk); #1;
    check("E0 busy", 32'(busy), 32'(1));
    check("E0 owner", 32'(owner), 32'(0));
    check("E0 q", 32'(q), 32'h00);
    @(posedge clk); #1;
    check("E1 q held", 32'(q), 32'h00);
    @(posedge clk); #1;
    check("E2 q", 32'(q), 32'hF0);
    check("E2 q_bar", 32'(q_bar), 32'h0F);
    @(negedge clk);
    check("done pulse", 32'(done), 32'h1);
    req[0] = 1'b0;
    @(posedge clk); #1;
    check("E3 busy", 32'(busy), 32'(0));
    check("E3 done", 32'(done), 32'(0));
    @(negedge clk);

    // Mixed rule from AA
    do_cmd(1, 8'hAA, 8'h55, 8'hAA);
    do_cmd(2, 8'h0F, 8'h3C, 8'h87);
    check("mixed q", 32'(q), 32'h87);
    check("mixed q_bar", 32'(q_bar), 32'h78);

    // All-hold command still completes; moves rr_ptr to 0
    do_cmd(3, 8'h00, 8'h00, 8'h87);

    // Full contention: 0,1,2,3 one every 4 cycles
    set_cmd(0, 8'h00, 8'h80);
    set_cmd(1, 8'hF0, 8'h00);
    set_cmd(2, 8'h0F, 8'h0F);
    set_cmd(3, 8'h00, 8'hFF);
    expect_done(0, 8'h07);
    expect_done(1, 8'hF7);
    expect_done(2, 8'hF8);
    expect_done(3, 8'h00);
    req = '1;
    wait_grant(0, 3);
    wait_grant(1, 4);
    wait_grant(2, 4);
    wait_grant(3, 4);
    @(negedge clk);

    // req 0 and 2 with rr_ptr=0
    set_cmd(0, 8'hFF, 8'h00);
    set_cmd(2, 8'h00, 8'h0F);
    expect_done(0, 8'hFF);
    expect_done(2, 8'hF0);
    req[0] = 1'b1;
    req[2] = 1'b1;
    wait_grant(0, 3);
    wait_grant(2, 4);
    @(negedge clk);

    // After owner 3, req 3 and 1 together: 1 first
    do_cmd(3, 8'h00, 8'h00, 8'hF0);
    set_cmd(1, 8'h0F, 8'h00);
    set_cmd(3, 8'h00, 8'hF0);
    expect_done(1, 8'hFF);
    expect_done(3, 8'h0F);
    req[1] = 1'b1;
    req[3] = 1'b1;
    wait_grant(1, 3);
    wait_grant(3, 4);
    @(negedge clk);

    // Toggle with req dropped and J/K scrambled in MASTER
    do_cmd(0, 8'hF0, 8'h0F, 8'hF0);
    set_cmd(1, 8'hFF, 8'hFF);
    expect_done(1, 8'h0F);
    req[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req[1] = 1'b0;
    set_cmd(1, 8'h00, 8'hFF);
    wait_grant(1, 2);
    @(negedge clk);
    check("toggle q", 32'(q), 32'h0F);

    // Reset while in SLAVE discards the command
    set_cmd(2, 8'hFF, 8'h00);
    req[2] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b0;
    req[2] = 1'b0;
    @(posedge clk); #1;
    check("midreset q", 32'(q), 32'h00);
    check("midreset q_bar", 32'(q_bar), 32'hFF);
    check("midreset busy", 32'(busy), 32'(0));
    check("midreset done", 32'(done), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset idle", 32'(busy), 32'(0));

    // rr_ptr back at 0: 1 wins over 3
    set_cmd(1, 8'h0F, 8'h00);
    set_cmd(3, 8'h00, 8'h0F);
    expect_done(1, 8'h0F);
    expect_done(3, 8'h00);
    req[1] = 1'b1;
    req[3] = 1'b1;
    wait_grant(1, 3);
    wait_grant(3, 4);
    @(negedge clk);

    // Re-request of the discarded set
    do_cmd(2, 8'hFF, 8'h00, 8'hFF);

    repeat (3) @(negedge clk);
    check("scoreboard drained", 32'(sb.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
